// File: rtl/vram_write_arbiter.sv
// VRAM-domain arbiter: scanout reads, queued GPMC writes and a hardware clear engine
// share four SPRAM banks with one access per clock.
module vram_write_arbiter #(
  parameter int unsigned STALL_LIMIT = 8,
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [15:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_req,
  output logic        o_rd_ready,
  input  logic [15:0] i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_clear_start,
  output logic        o_clear_busy,
  output logic        o_clear_done,
  output logic [13:0] o_ram_addr,
  output logic [15:0] o_ram_wdata,
  output logic [3:0]  o_ram_cs,
  output logic        o_ram_we,
  input  logic [63:0] i_ram_rdata
);

  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [15:0]         r_clear_addr;
  logic [15:0]         w_clear_addr_d;
  logic                r_clear_done;
  logic                w_clear_done_d;
  logic [StallW-1:0]   r_stall_cnt;

  logic                w_wr_pend;
  logic                w_force;
  logic                w_rd_grant;
  logic                w_wr_grant;
  logic [15:0]         w_wr_addr;
  logic [15:0]         w_wr_data;

  logic [13:0]         r_ram_addr;
  logic [15:0]         r_ram_wdata;
  logic [3:0]          r_ram_cs;
  logic                r_ram_we;

  // Read pipeline: p0 = request presented to SPRAM, p1 = SPRAM output valid.
  logic                r_rd_p0;
  logic                r_rd_p1;
  logic [1:0]          r_bank_p0;
  logic [1:0]          r_bank_p1;
  logic [15:0]         r_rd_data;
  logic                r_rd_valid;

  // In CLEAR the clear engine owns the write slot and is always pending.
  assign w_wr_pend  = (r_state == StClear) ? 1'b1 : i_wr_valid;
  assign w_force    = w_wr_pend && (r_stall_cnt == StallW'(STALL_LIMIT));
  assign w_rd_grant = i_rd_req && !w_force;
  assign w_wr_grant = w_wr_pend && !w_rd_grant;

  assign w_wr_addr  = (r_state == StClear) ? r_clear_addr : i_wr_addr;
  assign w_wr_data  = (r_state == StClear) ? CLEAR_VALUE : i_wr_data;

  // Handshakes are gated by reset so every output reads 0 while held in reset.
  assign o_rd_ready = i_reset_n && !w_force;
  assign o_wr_ready = i_reset_n && (r_state == StIdle) && (!i_rd_req || w_force);

  assign o_clear_busy = (r_state == StClear);
  assign o_clear_done = r_clear_done;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_ram_cs     = r_ram_cs;
  assign o_ram_we     = r_ram_we;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StIdle;
      r_clear_addr <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_clear_addr <= w_clear_addr_d;
      r_clear_done <= w_clear_done_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_clear_addr_d = r_clear_addr;
    w_clear_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A write accepted in the same cycle is still issued this cycle.
        if (i_clear_start) begin
          w_state_d      = StClear;
          w_clear_addr_d = '0;
        end
      end
      StClear: begin
        if (w_wr_grant) begin
          w_clear_addr_d = r_clear_addr + 16'd1;
          if (r_clear_addr == 16'hFFFF) begin
            w_state_d      = StIdle;
            w_clear_done_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= '0;
    end else if (!w_wr_pend || w_wr_grant) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != StallW'(STALL_LIMIT)) begin
      r_stall_cnt <= r_stall_cnt + StallW'(1);
    end
  end

  // Address and data hold when idle so the banks see no spurious toggling.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_cs    <= '0;
      r_ram_we    <= 1'b0;
    end else if (w_rd_grant) begin
      r_ram_addr  <= i_rd_addr[13:0];
      r_ram_cs    <= 4'b0001 << i_rd_addr[15:14];
      r_ram_we    <= 1'b0;
    end else if (w_wr_grant) begin
      r_ram_addr  <= w_wr_addr[13:0];
      r_ram_wdata <= w_wr_data;
      r_ram_cs    <= 4'b0001 << w_wr_addr[15:14];
      r_ram_we    <= 1'b1;
    end else begin
      r_ram_cs    <= '0;
      r_ram_we    <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_p0    <= 1'b0;
      r_rd_p1    <= 1'b0;
      r_bank_p0  <= '0;
      r_bank_p1  <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_p0    <= w_rd_grant;
      r_bank_p0  <= i_rd_addr[15:14];
      r_rd_p1    <= r_rd_p0;
      r_bank_p1  <= r_bank_p0;
      r_rd_valid <= r_rd_p1;
      if (r_rd_p1) begin
        r_rd_data <= i_ram_rdata[16*r_bank_p1 +: 16];
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter with a behavioural four-bank SPRAM model.
module tb_vram_write_arbiter;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic        rd_ready;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [3:0]  ram_cs;
  logic        ram_we;
  logic [63:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [4][16384];

  vram_write_arbiter #(
    .STALL_LIMIT (8),
    .CLEAR_VALUE (16'h0000)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_rd_req      (rd_req),
    .o_rd_ready    (rd_ready),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .i_clear_start (clear_start),
    .o_clear_busy  (clear_busy),
    .o_clear_done  (clear_done),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .o_ram_cs      (ram_cs),
    .o_ram_we      (ram_we),
    .i_ram_rdata   (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPRAM model: synchronous write, registered read output that holds when idle.
  initial ram_rdata = '0;
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_cs[n]) begin
        if (ram_we) mem[n][ram_addr] <= ram_wdata;
        else        ram_rdata[16*n +: 16] <= mem[n][ram_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
    tick();
  endtask

  int cycles;
  int wr_rdy_seen;

  initial begin
    reset_n     = 1'b0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    clear_start = 1'b0;
    tick();
    tick();
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_ram_cs", ram_cs, 4'b0000);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_busy", clear_busy, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single write to bank 1
    wr_valid = 1'b1;
    wr_addr  = 16'h4123;
    wr_data  = 16'hBEEF;
    #1;
    chk("t1_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
    chk("t1_cs", ram_cs, 4'b0010);
    chk("t1_addr", ram_addr, 14'h0123);
    chk("t1_we", ram_we, 1'b1);
    chk("t1_wdata", ram_wdata, 16'hBEEF);

    // Readback with exact three-edge latency
    rd_req  = 1'b1;
    rd_addr = 16'h4123;
    #1;
    chk("t2_rd_ready", rd_ready, 1'b1);
    tick();
    rd_req = 1'b0;
    chk("t2_cs", ram_cs, 4'b0010);
    chk("t2_we", ram_we, 1'b0);
    chk("t2_valid_e0", rd_valid, 1'b0);
    tick();
    chk("t2_valid_e1", rd_valid, 1'b0);
    tick();
    chk("t2_valid_e2", rd_valid, 1'b1);
    chk("t2_data", rd_data, 16'hBEEF);
    tick();
    chk("t2_valid_after", rd_valid, 1'b0);

    // Back-to-back reads across banks
    do_write(16'h0005, 16'h1111);
    do_write(16'h8007, 16'h2222);
    do_write(16'hC009, 16'h3333);
    rd_req  = 1'b1;
    rd_addr = 16'hC009;
    tick();
    rd_addr = 16'h0005;
    tick();
    rd_addr = 16'h8007;
    tick();
    rd_req = 1'b0;
    chk("b2b_v0", rd_valid, 1'b1);
    chk("b2b_d0", rd_data, 16'h3333);
    tick();
    chk("b2b_v1", rd_valid, 1'b1);
    chk("b2b_d1", rd_data, 16'h1111);
    tick();
    chk("b2b_v2", rd_valid, 1'b1);
    chk("b2b_d2", rd_data, 16'h2222);
    tick();
    chk("b2b_v3", rd_valid, 1'b0);

    // Starvation guard: write forced through every 9th cycle
    wr_valid = 1'b1;
    wr_addr  = 16'h0010;
    wr_data  = 16'hA5A5;
    rd_req   = 1'b1;
    rd_addr  = 16'h0005;
    #1;
    for (int k = 1; k <= 18; k++) begin
      chk("t3_rd_ready", rd_ready, (k % 9) != 0);
      chk("t3_wr_ready", wr_ready, (k % 9) == 0);
      tick();
      chk("t3_we", ram_we, (k % 9) == 0);
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    tick();
    tick();
    tick();
    do_read("t3_rb", 16'h0010, 16'hA5A5);

    // Full clear with no reads; a held write must never be accepted
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("t4_busy_start", clear_busy, 1'b1);
    wr_valid = 1'b1;
    wr_addr  = 16'h4123;
    wr_data  = 16'h1234;
    cycles      = 0;
    wr_rdy_seen = 0;
    while (clear_busy === 1'b1 && cycles < 70000) begin
      if (wr_ready !== 1'b0) wr_rdy_seen++;
      tick();
      cycles++;
    end
    wr_valid = 1'b0;
    chk("t4_cycles", cycles, 65536);
    chk("t4_wr_ready_seen", wr_rdy_seen, 0);
    chk("t4_done", clear_done, 1'b1);
    chk("t4_last_addr", ram_addr, 14'h3FFF);
    chk("t4_last_cs", ram_cs, 4'b1000);
    tick();
    chk("t4_done_pulse", clear_done, 1'b0);
    do_read("t4_rb0000", 16'h0000, 16'h0000);
    do_read("t4_rb7fff", 16'h7FFF, 16'h0000);
    do_read("t4_rbffff", 16'hFFFF, 16'h0000);
    do_read("t4_rb4123", 16'h4123, 16'h0000);

    // Clear start alongside a write accept, then reads every other cycle
    do_write(16'hF000, 16'h5A5A);
    wr_valid    = 1'b1;
    wr_addr     = 16'h2222;
    wr_data     = 16'h7777;
    clear_start = 1'b1;
    #1;
    chk("t5_wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid    = 1'b0;
    clear_start = 1'b0;
    chk("t5_we", ram_we, 1'b1);
    chk("t5_addr", ram_addr, 14'h2222);
    chk("t5_cs", ram_cs, 4'b0001);
    chk("t5_wdata", ram_wdata, 16'h7777);
    chk("t5_busy", clear_busy, 1'b1);
    for (int c = 0; c < 200; c++) begin
      rd_req  = (c % 2) == 0;
      rd_addr = ((c % 4) == 0) ? 16'hF000 : 16'h2222;
      #1;
      if (rd_req) chk("t5_rd_ready", rd_ready, 1'b1);
      tick();
      chk("t5_we_slot", ram_we, (c % 2) == 1);
      chk("t5_valid", rd_valid, (c >= 2) && ((c % 2) == 0));
      if (c >= 2 && (c % 2) == 0)
        chk("t5_data", rd_data, ((c - 2) % 4 == 0) ? 16'h5A5A : 16'h7777);
    end
    rd_req = 1'b0;
    tick();
    chk("t5_tail_valid", rd_valid, 1'b1);
    chk("t5_tail_data", rd_data, 16'h7777);
    chk("t5_still_busy", clear_busy, 1'b1);

    // Reset one cycle after a read accept, mid-clear
    rd_req  = 1'b1;
    rd_addr = 16'hF000;
    tick();
    rd_req  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_cs", ram_cs, 4'b0000);
    chk("t6_we", ram_we, 1'b0);
    chk("t6_valid", rd_valid, 1'b0);
    chk("t6_busy", clear_busy, 1'b0);
    chk("t6_rd_ready", rd_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_valid", rd_valid, 1'b0);
      chk("t6_idle_cs", ram_cs, 4'b0000);
    end
    chk("t6_busy_after", clear_busy, 1'b0);
    wr_valid = 1'b1;
    wr_addr  = 16'h0001;
    #1;
    chk("t6_idle_wr_ready", wr_ready, 1'b1);
    wr_valid    = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    chk("t6_clr_addr0", ram_addr, 14'h0000);
    chk("t6_clr_cs0", ram_cs, 4'b0001);
    chk("t6_clr_we0", ram_we, 1'b1);
    tick();
    chk("t6_clr_addr1", ram_addr, 14'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
